// File: rtl/tetris_pkg.sv
// Shared command encoding, FSM state types and priority pick
// for the tetris input path.
package tetris_pkg;

  localparam int CMD_DOWN   = 0;
  localparam int CMD_RIGHT  = 1;
  localparam int CMD_LEFT   = 2;
  localparam int CMD_ROTATE = 3;
  localparam int CMD_W      = 4;

  typedef enum logic [1:0] {
    R_IDLE,
    R_DELAY,
    R_REPEAT
  } rep_state_e;

  typedef enum logic {
    O_IDLE,
    O_VALID
  } out_state_e;

  // Command priority: rotate > left > right > down.
  function automatic logic [CMD_W-1:0] prio_pick(
    input logic [CMD_W-1:0] v
  );
    logic [CMD_W-1:0] r;
    r = '0;
    priority case (1'b1)
      v[CMD_ROTATE]: r[CMD_ROTATE] = 1'b1;
      v[CMD_LEFT]:   r[CMD_LEFT]   = 1'b1;
      v[CMD_RIGHT]:  r[CMD_RIGHT]  = 1'b1;
      v[CMD_DOWN]:   r[CMD_DOWN]   = 1'b1;
      default:       r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer followed by a stable-level debounce
// counter for one raw button.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (sync2_q != lvl_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        lvl_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = lvl_q;

endmodule

// File: rtl/tetris_command_encoder.sv
// Buttons to one-hot command stream: debounce, auto-repeat,
// gravity, pending merge and a valid/ready output stage.
module tetris_command_encoder
  import tetris_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 32,
  parameter int REPEAT_RATE     = 8,
  parameter int GRAVITY_PERIOD  = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CMD_W-1:0] buttons,
  input  logic             gravity_en,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [CMD_W-1:0] held
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam int GW   = $clog2(GRAVITY_PERIOD + 1);

  for (genvar i = 0; i < CMD_W; i++) begin : g_db
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clock),
      .rst_n(reset),
      .raw  (buttons[i]),
      .level(held[i])
    );
  end

  logic [CMD_W-1:0] held_prev_q;
  logic [CMD_W-1:0] press;
  logic [CMD_W-1:0] trk_now;

  rep_state_e       rstate_q, rstate_d;
  logic [CMD_W-1:0] trk_q, trk_d;
  logic [RW-1:0]    rcnt_q, rcnt_d;
  logic [CMD_W-1:0] rep_set;

  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic             grav_set;

  logic [CMD_W-1:0] pending_q, pending_d;
  logic [CMD_W-1:0] clr;

  out_state_e       ostate_q, ostate_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic             valid_q, valid_d;

  assign press   = held & ~held_prev_q;
  assign trk_now = prio_pick({1'b0, held[CMD_LEFT:CMD_DOWN]});

  // Release or change of the tracked button overrides the timer.
  always_comb begin
    rstate_d = rstate_q;
    trk_d    = trk_q;
    rcnt_d   = rcnt_q;
    rep_set  = '0;
    if (trk_now == '0) begin
      rstate_d = R_IDLE;
      trk_d    = '0;
      rcnt_d   = '0;
    end else if (trk_now != trk_q) begin
      rstate_d = R_DELAY;
      trk_d    = trk_now;
      rcnt_d   = '0;
    end else begin
      unique case (rstate_q)
        R_DELAY: begin
          if (rcnt_q == RW'(REPEAT_DELAY - 1)) begin
            rstate_d = R_REPEAT;
            rcnt_d   = '0;
            rep_set  = trk_q;
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
        end
        R_REPEAT: begin
          if (rcnt_q == RW'(REPEAT_RATE - 1)) begin
            rcnt_d  = '0;
            rep_set = trk_q;
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
        end
        default: rstate_d = R_IDLE;
      endcase
    end
  end

  always_comb begin
    gcnt_d   = '0;
    grav_set = 1'b0;
    if (gravity_en) begin
      if (gcnt_q == GW'(GRAVITY_PERIOD - 1)) begin
        grav_set = 1'b1;
      end else begin
        gcnt_d = gcnt_q + GW'(1);
      end
    end
  end

  always_comb begin
    ostate_d = ostate_q;
    cmd_d    = cmd_q;
    valid_d  = valid_q;
    clr      = '0;
    unique case (ostate_q)
      O_IDLE: begin
        if (|pending_q) begin
          clr      = prio_pick(pending_q);
          cmd_d    = clr;
          valid_d  = 1'b1;
          ostate_d = O_VALID;
        end
      end
      O_VALID: begin
        if (cmd_ready) begin
          cmd_d    = '0;
          valid_d  = 1'b0;
          ostate_d = O_IDLE;
        end
      end
      default: ostate_d = O_IDLE;
    endcase
  end

  // Sets are ORed in after the clear so a same-cycle set wins.
  always_comb begin
    pending_d = (pending_q & ~clr) | press | rep_set |
                {{(CMD_W-1){1'b0}}, grav_set};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      held_prev_q <= '0;
      rstate_q    <= R_IDLE;
      trk_q       <= '0;
      rcnt_q      <= '0;
      gcnt_q      <= '0;
      pending_q   <= '0;
      ostate_q    <= O_IDLE;
      cmd_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      held_prev_q <= held;
      rstate_q    <= rstate_d;
      trk_q       <= trk_d;
      rcnt_q      <= rcnt_d;
      gcnt_q      <= gcnt_d;
      pending_q   <= pending_d;
      ostate_q    <= ostate_d;
      cmd_q       <= cmd_d;
      valid_q     <= valid_d;
    end
  end

  assign cmd       = cmd_q;
  assign cmd_valid = valid_q;

endmodule

// File: tb/tb_tetris_command_encoder.sv
// Directed scenario bench for tetris_command_encoder with
// D=4, repeat delay 10, repeat rate 4, gravity period 20.
module tb_tetris_command_encoder;

  logic       clock;
  logic       reset;
  logic [3:0] buttons;
  logic       gravity_en;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] held;

  int vectors;
  int miscompares;

  tetris_command_encoder #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_RATE    (4),
    .GRAVITY_PERIOD (20)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .buttons   (buttons),
    .gravity_en(gravity_en),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .held      (held)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle(input int n);
    buttons = 4'b0000;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    buttons    = 4'b0000;
    gravity_en = 1'b0;
    cmd_ready  = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    vectors++;
    if (cmd !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_cmd: got %b want 0000", cmd);
    end
    vectors++;
    if (cmd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid: got %b want 0", cmd_valid);
    end
    vectors++;
    if (held !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_held: got %b want 0000", held);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_clean_press();
    int   nrise;
    logic prev;
    nrise   = 0;
    prev    = 1'b0;
    buttons = 4'b1000;
    for (int n = 1; n <= 45; n++) begin
      tick();
      if (n == 30) buttons = 4'b0000;
      if (n == 7) begin
        vectors++;
        if (cmd_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL press_early: edge7 valid %b want 0", cmd_valid);
        end
      end
      if (n == 8) begin
        vectors++;
        if (cmd_valid !== 1'b1 || cmd !== 4'b1000) begin
          miscompares++;
          $display("FAIL press_edge8: valid %b cmd %b want 1 1000",
                   cmd_valid, cmd);
        end
      end
      if (n == 10) begin
        vectors++;
        if (held !== 4'b1000) begin
          miscompares++;
          $display("FAIL press_held: got %b want 1000", held);
        end
      end
      if (cmd_valid && !prev) nrise++;
      prev = cmd_valid;
    end
    vectors++;
    if (nrise != 1) begin
      miscompares++;
      $display("FAIL press_count: got %0d commands want 1", nrise);
    end
  endtask

  task automatic test_glitch();
    logic held_seen;
    logic valid_seen;
    held_seen  = 1'b0;
    valid_seen = 1'b0;
    buttons    = 4'b0100;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 3) buttons = 4'b0000;
      if (held != 4'b0000) held_seen = 1'b1;
      if (cmd_valid) valid_seen = 1'b1;
    end
    vectors++;
    if (held_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_held: held changed, want 0000");
    end
    vectors++;
    if (valid_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_valid: valid rose, want never");
    end
  endtask

  task automatic test_auto_repeat();
    int   got[$];
    int   exp[9];
    logic prev;
    exp     = '{8, 18, 22, 26, 30, 34, 38, 42, 46};
    prev    = 1'b0;
    buttons = 4'b0010;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (n == 40) buttons = 4'b0000;
      if (cmd_valid && !prev) begin
        got.push_back(n);
        vectors++;
        if (cmd !== 4'b0010) begin
          miscompares++;
          $display("FAIL repeat_cmd: edge %0d cmd %b want 0010",
                   n, cmd);
        end
      end
      prev = cmd_valid;
    end
    vectors++;
    if (got.size() != 9) begin
      miscompares++;
      $display("FAIL repeat_count: got %0d want 9", got.size());
    end
    for (int i = 0; i < 9; i++) begin
      if (i < got.size()) begin
        vectors++;
        if (got[i] != exp[i]) begin
          miscompares++;
          $display("FAIL repeat_edge%0d: got %0d want %0d",
                   i, got[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_priority();
    logic late_seen;
    late_seen  = 1'b0;
    cmd_ready  = 1'b0;
    buttons    = 4'b1001;
    gravity_en = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (n == 6) buttons = 4'b0000;
      if (n == 7) begin
        vectors++;
        if (cmd_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL prio_early: valid %b want 0", cmd_valid);
        end
      end
      if (n == 8 || n == 30) begin
        vectors++;
        if (cmd_valid !== 1'b1 || cmd !== 4'b1000) begin
          miscompares++;
          $display("FAIL prio_rotate: edge %0d valid %b cmd %b want 1 1000",
                   n, cmd_valid, cmd);
        end
      end
      if (n == 30) begin
        gravity_en = 1'b0;
        cmd_ready  = 1'b1;
      end
      if (n == 31) begin
        cmd_ready = 1'b0;
        vectors++;
        if (cmd_valid !== 1'b0 || cmd !== 4'b0000) begin
          miscompares++;
          $display("FAIL prio_bubble: valid %b cmd %b want 0 0000",
                   cmd_valid, cmd);
        end
      end
      if (n == 32) begin
        vectors++;
        if (cmd_valid !== 1'b1 || cmd !== 4'b0001) begin
          miscompares++;
          $display("FAIL prio_down: valid %b cmd %b want 1 0001",
                   cmd_valid, cmd);
        end
      end
      if (n == 34) cmd_ready = 1'b1;
      if (n == 35) cmd_ready = 1'b0;
      if (n > 35 && cmd_valid) late_seen = 1'b1;
    end
    vectors++;
    if (late_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_coalesce: extra command after down");
    end
    cmd_ready = 1'b1;
  endtask

  task automatic test_gravity();
    int   got[$];
    int   exp[4];
    logic prev;
    exp        = '{21, 41, 61, 87};
    prev       = 1'b0;
    cmd_ready  = 1'b1;
    gravity_en = 1'b1;
    for (int n = 1; n <= 95; n++) begin
      tick();
      if (n == 65) gravity_en = 1'b0;
      if (n == 66) gravity_en = 1'b1;
      if (cmd_valid && !prev) begin
        got.push_back(n);
        vectors++;
        if (cmd !== 4'b0001) begin
          miscompares++;
          $display("FAIL gravity_cmd: edge %0d cmd %b want 0001",
                   n, cmd);
        end
      end
      prev = cmd_valid;
    end
    gravity_en = 1'b0;
    vectors++;
    if (got.size() != 4) begin
      miscompares++;
      $display("FAIL gravity_count: got %0d want 4", got.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) begin
        vectors++;
        if (got[i] != exp[i]) begin
          miscompares++;
          $display("FAIL gravity_edge%0d: got %0d want %0d",
                   i, got[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    cmd_ready = 1'b0;
    buttons   = 4'b1000;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 8) begin
        vectors++;
        if (cmd_valid !== 1'b1 || cmd !== 4'b1000) begin
          miscompares++;
          $display("FAIL rstmid_pre: valid %b cmd %b want 1 1000",
                   cmd_valid, cmd);
        end
      end
      if (n == 10) reset = 1'b0;
      if (n == 11) begin
        vectors++;
        if (cmd_valid !== 1'b0 || cmd !== 4'b0000 ||
            held !== 4'b0000) begin
          miscompares++;
          $display("FAIL rstmid_drop: valid %b cmd %b held %b want 0 0000 0000",
                   cmd_valid, cmd, held);
        end
      end
      if (n == 12) reset = 1'b1;
      if (n == 18) begin
        vectors++;
        if (held !== 4'b1000) begin
          miscompares++;
          $display("FAIL rstmid_held: got %b want 1000", held);
        end
      end
      if (n == 19) begin
        vectors++;
        if (cmd_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL rstmid_early: valid %b want 0", cmd_valid);
        end
      end
      if (n == 20) begin
        vectors++;
        if (cmd_valid !== 1'b1 || cmd !== 4'b1000) begin
          miscompares++;
          $display("FAIL rstmid_repress: valid %b cmd %b want 1 1000",
                   cmd_valid, cmd);
        end
      end
      if (n == 22) begin
        buttons   = 4'b0000;
        cmd_ready = 1'b1;
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    buttons     = 4'b0000;
    gravity_en  = 1'b0;
    cmd_ready   = 1'b1;
    test_reset();
    test_clean_press();
    settle(10);
    test_glitch();
    settle(10);
    test_auto_repeat();
    settle(10);
    test_priority();
    settle(10);
    test_gravity();
    settle(10);
    test_reset_mid();
    settle(5);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
